// File: rtl/ls_queue_pkg.sv
// ============================================================================
// Package : ls_queue_pkg
// Desc    : Shared defines, FSM encodings and load formatting for ls_queue.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`define ADDR_T       logic [31:0]
`define WORD_T       logic [31:0]
`define BYTE_T       logic [7:0]
`define NULL_PTR     32'h0000_0000
`define READ_SIGNAL  1'b0
`define WRITE_SIGNAL 1'b1
`define ZERO         32'h0000_0000

package ls_queue_pkg;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_ISSUE   = 2'd1;
  localparam logic [1:0] c_ST_WAIT_LD = 2'd2;
  localparam logic [1:0] c_ST_DRAIN   = 2'd3;

  // The cache returns byte0 in the most significant byte of the access;
  // reverse so byte0 lands in bits [7:0], then extend from the access size.
  function automatic `WORD_T fmt_load(input `WORD_T v, input logic [7:0] size,
                                      input logic sgn);
    `BYTE_T b0;
    `BYTE_T b1;
    `WORD_T r;
    r = `ZERO;
    case (size)
      8'd1: begin
        b0 = v[7:0];
        r  = {{24{sgn & b0[7]}}, b0};
      end
      8'd2: begin
        b0 = v[15:8];
        b1 = v[7:0];
        r  = {{16{sgn & b1[7]}}, b1, b0};
      end
      default: r = {v[7:0], v[15:8], v[23:16], v[31:24]};
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ls_queue_fifo.sv
// ============================================================================
// Module  : ls_queue_fifo
// Desc    : Synchronous ring buffer holding queued load/store entries.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ls_queue_fifo
  import ls_queue_pkg::*;
#(
  parameter int DEPTH_WIDTH = 3,
  parameter int WIDTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_WIDTH:0]   count
);

  localparam int                     c_DEPTH    = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   c_FULL_CNT = (DEPTH_WIDTH+1)'(c_DEPTH);
  localparam logic [DEPTH_WIDTH:0]   c_CNT_ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] c_PTR_ONE  = DEPTH_WIDTH'(1);

  logic [WIDTH-1:0]       r_mem [c_DEPTH];
  logic [DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [DEPTH_WIDTH:0]   r_count;
  logic                   r_full;
  logic                   w_push_ok;
  logic                   w_pop_ok;
  logic [DEPTH_WIDTH:0]   w_count_next;

  // Full is registered, so a pop in the same cycle never makes room for a push.
  assign w_push_ok = push & ~r_full & ~flush;
  assign w_pop_ok  = pop & (r_count != '0) & ~flush;

  always_comb begin
    w_count_next = r_count;
    if (w_push_ok && !w_pop_ok) begin
      w_count_next = r_count + c_CNT_ONE;
    end else if (w_pop_ok && !w_push_ok) begin
      w_count_next = r_count - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = r_full;
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ls_queue.sv
// ============================================================================
// Module  : ls_queue
// Desc    : In-order load/store queue issuing one op at a time to the cache.
// Config  : LS_SIGN_EXT_EN enables sign extension of signed byte/half loads.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ls_queue
  import ls_queue_pkg::*;
#(
  parameter int DEPTH_WIDTH = 3,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_valid,
  input  logic                 in_oper,
  input  logic [31:0]          in_addr,
  input  logic [31:0]          in_data,
  input  logic [7:0]           in_size,
  input  logic                 in_signed,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 full,
  input  logic                 flush,
  output logic                 en_ls,
  output logic                 ls_oper,
  output logic [31:0]          ls_addr,
  output logic [31:0]          ls_data,
  output logic [7:0]           ls_size,
  input  logic                 in_fifo,
  input  logic                 finish,
  input  logic [31:0]          ls_data_out,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [31:0]          out_data
);

`ifdef LS_SIGN_EXT_EN
  localparam int c_ENTRY_W = 74 + TAG_WIDTH;
`else
  localparam int c_ENTRY_W = 73 + TAG_WIDTH;
`endif

  logic [c_ENTRY_W-1:0] w_push_entry;
  logic [c_ENTRY_W-1:0] w_head;
  logic                 w_head_oper;
  `ADDR_T               w_head_addr;
  `WORD_T               w_head_data;
  logic [7:0]           w_head_size;
  logic [TAG_WIDTH-1:0] w_head_tag;
  logic                 w_ld_signed;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DEPTH_WIDTH:0] w_unused_count;
  logic                 w_head_vis;

  logic [1:0]           r_state;
  logic [1:0]           w_state_next;
  logic                 w_en_ls;
  logic                 w_capture;
  logic                 w_out_fire;

  logic [7:0]           r_ld_size;
  logic [TAG_WIDTH-1:0] r_ld_tag;
  logic                 r_out_valid;
  logic [TAG_WIDTH-1:0] r_out_tag;
  `WORD_T               r_out_data;

`ifdef LS_SIGN_EXT_EN
  logic                 w_head_signed;
  logic                 r_ld_signed;

  assign w_push_entry = {in_oper, in_addr, in_data, in_size, in_signed, in_tag};
  assign {w_head_oper, w_head_addr, w_head_data, w_head_size, w_head_signed,
          w_head_tag} = w_head;
  assign w_ld_signed  = r_ld_signed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_signed <= 1'b0;
    end else if (w_capture) begin
      r_ld_signed <= w_head_signed;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = in_signed;
  assign w_push_entry    = {in_oper, in_addr, in_data, in_size, in_tag};
  assign {w_head_oper, w_head_addr, w_head_data, w_head_size, w_head_tag} = w_head;
  assign w_ld_signed     = 1'b0;
`endif

  // A null address would never be accepted by the cache, so it is never queued.
  assign w_push = in_valid & rdy & (in_addr != `NULL_PTR);

  ls_queue_fifo #(
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .WIDTH       (c_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .flush     (flush),
    .head      (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_unused_count)
  );

  always_comb begin
    w_state_next = r_state;
    w_en_ls      = 1'b0;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_out_fire   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (rdy && !flush && !w_fifo_empty) begin
          w_en_ls      = 1'b1;
          w_state_next = c_ST_ISSUE;
        end
      end
      c_ST_ISSUE: begin
        // Not accepted: drop back to IDLE so the next pulse is a cycle later.
        w_state_next = c_ST_IDLE;
        if (in_fifo) begin
          w_pop = 1'b1;
          if (w_head_oper == `READ_SIGNAL) begin
            w_capture    = 1'b1;
            w_state_next = flush ? c_ST_DRAIN : c_ST_WAIT_LD;
          end
        end
      end
      c_ST_WAIT_LD: begin
        if (flush) begin
          w_state_next = finish ? c_ST_IDLE : c_ST_DRAIN;
        end else if (finish) begin
          w_out_fire   = 1'b1;
          w_state_next = c_ST_IDLE;
        end
      end
      c_ST_DRAIN: begin
        if (finish) w_state_next = c_ST_IDLE;
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_size <= '0;
      r_ld_tag  <= '0;
    end else if (w_capture) begin
      r_ld_size <= w_head_size;
      r_ld_tag  <= w_head_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_out_data  <= `ZERO;
    end else begin
      r_out_valid <= w_out_fire;
      if (w_out_fire) begin
        r_out_tag  <= r_ld_tag;
        r_out_data <= fmt_load(ls_data_out, r_ld_size, w_ld_signed);
      end
    end
  end

  // Head fields stay visible while an op is being offered, so they are stable
  // across repeated pulses of the same request.
  assign w_head_vis = !w_fifo_empty && (r_state == c_ST_IDLE || r_state == c_ST_ISSUE);

  assign en_ls     = w_en_ls;
  assign ls_oper   = w_head_vis ? w_head_oper : 1'b0;
  assign ls_addr   = w_head_vis ? w_head_addr : `ZERO;
  assign ls_data   = w_head_vis ? w_head_data : `ZERO;
  assign ls_size   = w_head_vis ? w_head_size : 8'd0;
  assign full      = w_fifo_full;
  assign out_valid = r_out_valid;
  assign out_tag   = r_out_tag;
  assign out_data  = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_ls_queue.sv
// ============================================================================
// Module  : tb_ls_queue
// Desc    : Self-checking bench for ls_queue (honours LS_SIGN_EXT_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ls_queue;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic        clk = 1'b0;
  logic        rst, rdy, in_valid, in_oper, in_signed, flush, in_fifo, finish;
  logic [31:0] in_addr, in_data, ls_data_out;
  logic [7:0]  in_size;
  logic [3:0]  in_tag;
  logic        full, en_ls, ls_oper, out_valid;
  logic [31:0] ls_addr, ls_data, out_data;
  logic [7:0]  ls_size;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;

  ls_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_oper(in_oper),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size), .in_signed(in_signed),
    .in_tag(in_tag), .full(full), .flush(flush), .en_ls(en_ls), .ls_oper(ls_oper),
    .ls_addr(ls_addr), .ls_data(ls_data), .ls_size(ls_size), .in_fifo(in_fifo),
    .finish(finish), .ls_data_out(ls_data_out), .out_valid(out_valid),
    .out_tag(out_tag), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        oper;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  size;
    logic        sgn;
    logic [3:0]  tag;
  } op_t;

  typedef struct {
    logic [7:0]  size;
    logic        sgn;
    logic [31:0] v;
    logic [31:0] exp_z;
    logic [31:0] exp_s;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic op, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] sz, input logic sg, input logic [3:0] tg);
    in_valid = 1'b1; in_oper = op; in_addr = a; in_data = d;
    in_size = sz; in_signed = sg; in_tag = tg;
    next();
    in_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge of the pulse cycle.
  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (en_ls) ok = 1'b1;
      else next();
    end
  endtask

  task automatic run_load(input logic [7:0] sz, input logic sg, input logic [31:0] v,
                          input logic [3:0] tg, input logic [31:0] exp, input string nm);
    bit ok;
    enq(RD, 32'h0000_0100, 32'h0, sz, sg, tg);
    wait_pulse(ok);
    chk({nm, "_pulse"}, 32'(ok), 32'd1);
    next(); in_fifo = 1'b1;
    next(); in_fifo = 1'b0; finish = 1'b1; ls_data_out = v;
    next(); finish = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(tg));
    next();
  endtask

  // Reference formatting: pick byte i from the cache word and place it at lane i.
  function automatic logic [31:0] ref_fmt(input logic [31:0] v, input int sz, input bit sgn);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < sz; i++) r |= ((v >> (8 * (sz - 1 - i))) & 32'hFF) << (8 * i);
`ifdef LS_SIGN_EXT_EN
    if (sgn && sz < 4 && r[8*sz-1]) r |= ~((32'h1 << (8 * sz)) - 32'h1);
`else
    if (sgn) r = r;
`endif
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t  vt[5];
    bit    ok, seen_en, seen_ov;
    op_t   q[$];
    op_t   cur, ld_op, popped;
    bit    pend, ld_out, ld_disc, exp_ov, exp_en, fin, full_before, new_ov;
    int    ld_dly;
    logic [31:0] exp_od;
    logic [3:0]  exp_ot;

    vt[0] = '{8'd4, 1'b0, 32'h4433_2211, 32'h1122_3344, 32'h1122_3344};
    vt[1] = '{8'd1, 1'b1, 32'h0000_0080, 32'h0000_0080, 32'hFFFF_FF80};
    vt[2] = '{8'd2, 1'b1, 32'h0000_BBAA, 32'h0000_AABB, 32'hFFFF_AABB};
    vt[3] = '{8'd2, 1'b0, 32'h1234_8001, 32'h0000_0180, 32'h0000_0180};
    vt[4] = '{8'd1, 1'b1, 32'hFFFF_FF7F, 32'h0000_007F, 32'h0000_007F};

    rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_oper = RD; in_addr = 32'h0;
    in_data = 32'h0; in_size = 8'd4; in_signed = 1'b0; in_tag = 4'h0;
    flush = 1'b0; in_fifo = 1'b0; finish = 1'b0; ls_data_out = 32'h0;
    repeat (3) next();
    @(negedge clk);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_en_ls", 32'(en_ls), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_ls_addr", ls_addr, 32'h0);
    next(); rst = 1'b0; next();

    // Store: one pulse, accepted, no load result
    enq(WR, 32'h0000_0100, 32'h1122_3344, 8'd4, 1'b0, 4'h3);
    wait_pulse(ok);
    chk("st_pulse", 32'(ok), 32'd1);
    chk("st_ls_data", ls_data, 32'h1122_3344);
    chk("st_ls_addr", ls_addr, 32'h0000_0100);
    chk("st_ls_oper", 32'(ls_oper), 32'(WR));
    next(); in_fifo = 1'b1;
    next(); in_fifo = 1'b0;
    seen_en = 1'b0; seen_ov = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); seen_en |= en_ls; seen_ov |= out_valid; next();
    end
    chk("st_no_repulse", 32'(seen_en), 32'd0);
    chk("st_no_out_valid", 32'(seen_ov), 32'd0);

    // Load formatting table
    for (int i = 0; i < 5; i++) begin
`ifdef LS_SIGN_EXT_EN
      run_load(vt[i].size, vt[i].sgn, vt[i].v, 4'(i + 1), vt[i].exp_s, $sformatf("ld%0d", i));
`else
      run_load(vt[i].size, vt[i].sgn, vt[i].v, 4'(i + 1), vt[i].exp_z, $sformatf("ld%0d", i));
`endif
    end

    // in_fifo withheld three times: pulse every other cycle, stable fields
    enq(WR, 32'h0000_0340, 32'hCAFE_0001, 8'd2, 1'b0, 4'h7);
    wait_pulse(ok);
    chk("wh_first_pulse", 32'(ok), 32'd1);
    for (int r = 0; r < 3; r++) begin
      next(); @(negedge clk);
      chk("wh_gap", 32'(en_ls), 32'd0);
      next(); @(negedge clk);
      chk("wh_repulse", 32'(en_ls), 32'd1);
      chk("wh_addr", ls_addr, 32'h0000_0340);
    end
    next(); in_fifo = 1'b1;
    next(); in_fifo = 1'b0;
    seen_en = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); seen_en |= en_ls; next(); end
    chk("wh_single_pop", 32'(seen_en), 32'd0);

    // Fill to full, 9th dropped, drain in order
    for (int k = 0; k < 8; k++) enq(WR, 32'h0000_0500 + 32'(4 * k), 32'(k), 8'd4, 1'b0, 4'(k));
    @(negedge clk);
    chk("fill_full", 32'(full), 32'd1);
    enq(WR, 32'h0000_0900, 32'h9, 8'd4, 1'b0, 4'h9);
    @(negedge clk);
    chk("fill_still_full", 32'(full), 32'd1);
    next();
    for (int k = 0; k < 8; k++) begin
      wait_pulse(ok);
      chk("drain_pulse", 32'(ok), 32'd1);
      chk("drain_order", ls_addr, 32'h0000_0500 + 32'(4 * k));
      next(); in_fifo = 1'b1;
      next(); in_fifo = 1'b0;
    end
    seen_en = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen_en |= en_ls; next(); end
    chk("drain_9th_dropped", 32'(seen_en), 32'd0);
    chk("drain_not_full", 32'(full), 32'd0);

    // Flush in WAIT_LD with three queued
    enq(RD, 32'h0000_0200, 32'h0, 8'd4, 1'b0, 4'h5);
    wait_pulse(ok);
    chk("fl_pulse", 32'(ok), 32'd1);
    next(); in_fifo = 1'b1;
    next(); in_fifo = 1'b0;
    for (int k = 0; k < 3; k++) enq(WR, 32'h0000_0600 + 32'(4 * k), 32'h0, 8'd4, 1'b0, 4'h0);
    flush = 1'b1;
    next(); flush = 1'b0;
    finish = 1'b1; ls_data_out = 32'h1234_5678;
    next(); finish = 1'b0;
    seen_en = 1'b0; seen_ov = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); seen_en |= en_ls; seen_ov |= out_valid; next();
    end
    chk("fl_no_out_valid", 32'(seen_ov), 32'd0);
    chk("fl_queue_empty", 32'(seen_en), 32'd0);
    run_load(8'd4, 1'b0, 32'hDDCC_BBAA, 4'hE, 32'hAABB_CCDD, "fl_after");

    // Randomised traffic against the reference model
    rst = 1'b1; next(); next(); rst = 1'b0;
    pend = 0; ld_out = 0; ld_disc = 0; exp_ov = 0; ld_dly = 0;
    exp_od = 32'h0; exp_ot = 4'h0; ld_op = '0;
    for (int c = 0; c < 3000; c++) begin
      rdy       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      cur.oper  = $urandom_range(0, 1) == 1;
      cur.addr  = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h0000_1000);
      cur.data  = $urandom;
      case ($urandom_range(0, 2))
        0: cur.size = 8'd1;
        1: cur.size = 8'd2;
        default: cur.size = 8'd4;
      endcase
      cur.sgn   = $urandom_range(0, 1) == 1;
      cur.tag   = 4'($urandom_range(0, 15));
      in_oper = cur.oper; in_addr = cur.addr; in_data = cur.data;
      in_size = cur.size; in_signed = cur.sgn; in_tag = cur.tag;
      in_fifo = pend && ($urandom_range(0, 2) != 0);
      fin = ld_out && (ld_dly == 0);
      finish = fin;
      ls_data_out = $urandom;
      @(negedge clk);
      exp_en = !pend && !ld_out && rdy && !flush && (q.size() > 0);
      chk("rnd_full", 32'(full), 32'(q.size() == 8));
      chk("rnd_en_ls", 32'(en_ls), 32'(exp_en));
      chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("rnd_out_data", out_data, exp_od);
        chk("rnd_out_tag", 32'(out_tag), 32'(exp_ot));
      end
      if (exp_en && en_ls) begin
        chk("rnd_ls_addr", ls_addr, q[0].addr);
        chk("rnd_ls_oper", 32'(ls_oper), 32'(q[0].oper));
        if (q[0].oper == WR) chk("rnd_ls_data", ls_data, q[0].data);
        chk("rnd_ls_size", 32'(ls_size), 32'(q[0].size));
      end
      full_before = (q.size() == 8);
      new_ov = 1'b0;
      if (fin) begin
        if (!ld_disc && !flush) begin
          new_ov = 1'b1;
          exp_od = ref_fmt(ls_data_out, int'(ld_op.size), ld_op.sgn);
          exp_ot = ld_op.tag;
        end
        ld_out = 1'b0;
      end else if (ld_out) begin
        if (flush) ld_disc = 1'b1;
        ld_dly--;
      end
      if (pend && in_fifo && q.size() > 0) begin
        popped = q.pop_front();
        if (popped.oper == RD) begin
          ld_out = 1'b1; ld_disc = flush; ld_dly = $urandom_range(0, 3); ld_op = popped;
        end
      end
      pend = exp_en;
      if (flush) q.delete();
      else if (in_valid && rdy && cur.addr != 32'h0 && !full_before) q.push_back(cur);
      exp_ov = new_ov;
      next();
    end
    in_valid = 1'b0; flush = 1'b0; in_fifo = 1'b0; finish = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
